multicycle_control: RTL and testbench

Moore/Mealy control state machine for the RV64I multi-cycle core. It sequences a single shared datapath through fetch, decode, execute, memory and writeback for every instruction: one ALU, one unified memory port, the register file, and the immediate generator fed from the instruction register. It also stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions.

---
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 222 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the shared RV64I datapath.
// The master side is the sequencer; the slave side is the datapath/memory view.
interface multicycle_control_if;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;

    logic        inst_write;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        mem_addr_source;
    logic        reg_write;
    logic [1:0]  wb_source;
    logic        illegal_inst;
    logic [3:0]  state;
    logic [63:0] instret;

    modport master (
        input  opcode, mem_ready, branch_taken,
        output inst_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op,
               mem_read, mem_write, mem_addr_source, reg_write, wb_source,
               illegal_inst, state, instret
    );

    modport slave (
        output opcode, mem_ready, branch_taken,
        input  inst_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op,
               mem_read, mem_write, mem_addr_source, reg_write, wb_source,
               illegal_inst, state, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV64I control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory-ready stalls, sticky illegal-opcode trap and a retired-instruction counter.
//
// state | meaning
// ------+-----------------------------------------------
//   0   | FETCH     read inst at pc, pc <= pc+4 on ready
//   1   | DECODE    alu_out <= old_pc+imm, dispatch on opcode
//   2   | MEM_ADDR  alu_out <= rs1+imm
//   3   | MEM_READ  load access, wait for ready
//   4   | LOAD_WB   rd <= memory data
//   5   | MEM_WRITE store access, wait for ready
//   6   | EXEC_R    register-register ALU op
//   7   | EXEC_I    register-immediate ALU op
//   8   | ALU_WB    rd <= alu_out
//   9   | BRANCH    compare, pc <= alu_out if taken
//  10   | JAL       pc <= alu_out, rd <= old_pc+4
//  11   | JALR      pc <= (rs1+imm)&~1, rd <= old_pc+4
//  12   | LUI       alu_out <= 0+imm
//  15   | TRAP      illegal opcode, held until reset
module multicycle_control (
    input  logic                 clock,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_LOAD_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;
    localparam logic [3:0] S_JALR      = 4'd11;
    localparam logic [3:0] S_LUI       = 4'd12;
    localparam logic [3:0] S_TRAP      = 4'd15;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [3:0]  state_q, state_d;
    logic [63:0] instret_q, instret_d;

    logic        inst_write;
    logic        pc_write;
    logic [1:0]  pc_source;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        mem_addr_source;
    logic        reg_write;
    logic [1:0]  wb_source;
    logic        illegal_inst;
    logic        fetch_done;

    // Reset is folded in so a ready memory cannot pulse the Mealy strobes while reset is held.
    assign fetch_done = bus.mem_ready && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OPC_LOAD, OPC_STORE:     state_d = S_MEM_ADDR;
                    OPC_OP, OPC_OP_32:       state_d = S_EXEC_R;
                    OPC_OP_IMM, OPC_OP_IMM32: state_d = S_EXEC_I;
                    OPC_BRANCH:              state_d = S_BRANCH;
                    OPC_JAL:                 state_d = S_JAL;
                    OPC_JALR:                state_d = S_JALR;
                    OPC_LUI:                 state_d = S_LUI;
                    OPC_AUIPC:               state_d = S_ALU_WB;
                    OPC_FENCE, OPC_SYSTEM:   state_d = S_FETCH;
                    default:                 state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (bus.opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (bus.mem_ready) state_d = S_LOAD_WB;
            S_LOAD_WB:   state_d = S_FETCH;
            S_MEM_WRITE: if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_LUI:       state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JALR:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase

        // An instruction retires exactly when control returns to FETCH from elsewhere.
        instret_d = instret_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_comb begin
        inst_write      = 1'b0;
        pc_write        = 1'b0;
        pc_source       = 2'd0;
        alu_src_a       = 2'd0;
        alu_src_b       = 2'd0;
        alu_op          = 2'd0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_addr_source = 1'b0;
        reg_write       = 1'b0;
        wb_source       = 2'd0;
        illegal_inst    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'd2;
                inst_write = fetch_done;
                pc_write   = fetch_done;
            end
            S_DECODE: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
            end
            S_MEM_READ: begin
                mem_read        = 1'b1;
                mem_addr_source = 1'b1;
            end
            S_LOAD_WB: begin
                reg_write = 1'b1;
                wb_source = 2'd1;
            end
            S_MEM_WRITE: begin
                mem_write       = 1'b1;
                mem_addr_source = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd1;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                alu_op    = 2'd1;
            end
            S_LUI: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd2;
                pc_source = 2'd1;
                pc_write  = bus.branch_taken;
            end
            S_JAL: begin
                pc_write  = 1'b1;
                pc_source = 2'd1;
                reg_write = 1'b1;
                wb_source = 2'd2;
            end
            S_JALR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
                pc_source = 2'd2;
                reg_write = 1'b1;
                wb_source = 2'd2;
            end
            S_TRAP: begin
                illegal_inst = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.inst_write      = inst_write;
    assign bus.pc_write        = pc_write;
    assign bus.pc_source       = pc_source;
    assign bus.alu_src_a       = alu_src_a;
    assign bus.alu_src_b       = alu_src_b;
    assign bus.alu_op          = alu_op;
    assign bus.mem_read        = mem_read;
    assign bus.mem_write       = mem_write;
    assign bus.mem_addr_source = mem_addr_source;
    assign bus.reg_write       = reg_write;
    assign bus.wb_source       = wb_source;
    assign bus.illegal_inst    = illegal_inst;
    assign bus.state           = state_q;
    assign bus.instret         = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams
// checked cycle by cycle against a per-instruction state-path and output-table model.
module tb_multicycle_control;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;
    longint unsigned model_instret;
    int   path[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Output word: iw pw ps[2] a[2] b[2] op[2] mr mw mas rw wb[2] ill
    function automatic logic [16:0] pk(input logic iw, input logic pw, input logic [1:0] ps,
                                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                       input logic mr, input logic mw, input logic mas,
                                       input logic rw, input logic [1:0] wb, input logic ill);
        return {iw, pw, ps, a, b, op, mr, mw, mas, rw, wb, ill};
    endfunction

    function automatic logic [16:0] exp_out(input int st, input logic rdy, input logic tk);
        case (st)
            0:  return pk(rdy, rdy, 2'd0, 2'd0, 2'd2, 2'd0, 1, 0, 0, 0, 2'd0, 0);
            1:  return pk(0, 0, 2'd0, 2'd3, 2'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
            2:  return pk(0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
            3:  return pk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 1, 0, 2'd0, 0);
            4:  return pk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 2'd1, 0);
            5:  return pk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 1, 1, 0, 2'd0, 0);
            6:  return pk(0, 0, 2'd0, 2'd1, 2'd0, 2'd1, 0, 0, 0, 0, 2'd0, 0);
            7:  return pk(0, 0, 2'd0, 2'd1, 2'd1, 2'd1, 0, 0, 0, 0, 2'd0, 0);
            8:  return pk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 2'd0, 0);
            9:  return pk(0, tk, 2'd1, 2'd1, 2'd0, 2'd2, 0, 0, 0, 0, 2'd0, 0);
            10: return pk(0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 2'd2, 0);
            11: return pk(0, 1, 2'd2, 2'd1, 2'd1, 2'd0, 0, 0, 0, 1, 2'd2, 0);
            12: return pk(0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 0, 0, 0, 0, 2'd0, 0);
            15: return pk(0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 2'd0, 1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [16:0] out_vec();
        return {bus.inst_write, bus.pc_write, bus.pc_source, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.mem_read, bus.mem_write, bus.mem_addr_source, bus.reg_write,
                bus.wb_source, bus.illegal_inst};
    endfunction

    // Expected state walk of one instruction, written from the instruction class.
    task automatic build_path(input logic [6:0] opc);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        case (opc)
            7'b0000011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            7'b0100011: begin path.push_back(2); path.push_back(5); end
            7'b0110011, 7'b0111011: begin path.push_back(6); path.push_back(8); end
            7'b0010011, 7'b0011011: begin path.push_back(7); path.push_back(8); end
            7'b0110111: begin path.push_back(12); path.push_back(8); end
            7'b0010111: path.push_back(8);
            7'b1100011: path.push_back(9);
            7'b1101111: path.push_back(10);
            7'b1100111: path.push_back(11);
            7'b0001111, 7'b1110011: ;
            default: path.push_back(15);
        endcase
    endtask

    // Entered and left at posedge+1; checks at the falling edge.
    task automatic step(input int st, input logic rdy, input logic tk);
        bus.mem_ready    = rdy;
        bus.branch_taken = tk;
        @(negedge clock);
        check($sformatf("state_s%0d", st), 64'(bus.state), 64'(st));
        check($sformatf("outputs_s%0d", st), 64'(out_vec()), 64'(exp_out(st, rdy, tk)));
        check($sformatf("instret_s%0d", st), bus.instret, model_instret);
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw, input int tkm);
        logic tk;
        bus.opcode = opc;
        build_path(opc);
        foreach (path[i]) begin
            tk = (tkm == 2) ? 1'($urandom_range(0, 1)) : 1'(tkm);
            if (path[i] == 0 || path[i] == 3 || path[i] == 5) begin
                for (int w = 0; w < ((path[i] == 0) ? fw : mw); w++) step(path[i], 1'b0, tk);
                step(path[i], 1'b1, tk);
            end else begin
                step(path[i], 1'($urandom_range(0, 1)), tk);
            end
        end
        if (path[path.size()-1] != 15) model_instret++;
    endtask

    // Asserts reset asynchronously, checks the reset view, releases it at a falling edge.
    task automatic do_reset(input logic rdy);
        bus.mem_ready = rdy;
        reset = 1'b0;
        #1;
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_outputs", 64'(out_vec()), 64'(pk(0, 0, 2'd0, 2'd0, 2'd2, 2'd0, 1, 0, 0, 0, 2'd0, 0)));
        check("rst_instret", bus.instret, 64'd0);
        model_instret = 0;
        @(negedge clock);
        bus.mem_ready = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [6:0] legal_ops [13] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0111011, 7'b0010011,
                                   7'b0011011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'b0001111, 7'b1110011};

    initial begin
        logic [6:0] opc;
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        model_instret = 0;
        reset            = 1'b0;
        bus.opcode       = 7'd0;
        bus.mem_ready    = 1'b1;
        bus.branch_taken = 1'b0;
        #1;
        do_reset(1'b1);

        run_instr(7'b0110011, 0, 0, 0);
        run_instr(7'b0000011, 0, 2, 0);
        run_instr(7'b1100011, 0, 0, 0);
        run_instr(7'b1100011, 0, 0, 1);
        run_instr(7'b1100111, 0, 0, 0);
        run_instr(7'b0100011, 1, 3, 0);
        run_instr(7'b0010111, 0, 0, 0);
        run_instr(7'b0001111, 2, 0, 0);

        run_instr(7'b1111111, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        #2;
        do_reset(1'b1);

        // Abort a stalled store with an asynchronous reset.
        bus.opcode = 7'b0100011;
        step(0, 1'b1, 1'b0);
        step(1, 1'b0, 1'b0);
        step(2, 1'b0, 1'b0);
        bus.mem_ready = 1'b0;
        @(negedge clock);
        check("mw_before_abort", 64'(bus.mem_write), 64'd1);
        #2;
        do_reset(1'b0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) opc = 7'($urandom);
            else opc = legal_ops[$urandom_range(0, 12)];
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), 2);
            if (path[path.size()-1] == 15) begin
                for (int i = 0; i < 3; i++) step(15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                #2;
                do_reset(1'($urandom_range(0, 1)));
            end
        end
        step(0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
